// File: rtl/chacha_ks_xor_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : chacha_ks_xor_stream
//  Description : Consumes 512-bit ChaCha keystream blocks from the keystream
//                unit, slices each block into 128-bit lanes (lane 0 first) and
//                XORs them onto a valid/ready data stream. The output beat is
//                registered and carries byte-keep and last markers.
//  Ports       : clk, rst_n       clock, async active-low reset
//                start, busy      message start pulse / message in progress
//                ks_req           keystream block request (registered level)
//                ks_valid/ks_data keystream block delivery (one-cycle pulse)
//                in_*             input stream (valid/ready, data, keep, last)
//                out_*            output stream (valid/ready, data, keep, last)
//                blk_cnt          keystream blocks consumed in current message
//  Revision    : 1.0 - initial release
// ============================================================================
module chacha_ks_xor_stream #(
  parameter int DATA_W = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                ks_req,
  input  logic                ks_valid,
  input  logic [511:0]        ks_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [DATA_W/8-1:0] in_keep,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [DATA_W/8-1:0] out_keep,
  output logic                out_last,
  output logic [31:0]         blk_cnt
);

  localparam int LANES  = 512 / DATA_W;
  localparam int LANE_W = $clog2(LANES);
  localparam int KEEP_W = DATA_W / 8;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;

  logic [1:0]        state_q,     state_d;
  logic              busy_q,      busy_d;
  logic              ks_req_q,    ks_req_d;
  logic [511:0]      ks_buf_q,    ks_buf_d;
  logic [LANE_W-1:0] lane_q,      lane_d;
  logic [31:0]       blk_cnt_q,   blk_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [KEEP_W-1:0] out_keep_q,  out_keep_d;
  logic              out_last_q,  out_last_d;

  logic [DATA_W-1:0] lanes [LANES];
  logic [DATA_W-1:0] lane_sel;
  logic [DATA_W-1:0] xored;
  logic [DATA_W-1:0] masked;
  logic              beat_accept;

  // Lane i of the buffered block is bits [DATA_W*i +: DATA_W].
  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign lanes[i] = ks_buf_q[i*DATA_W +: DATA_W];
    end
  endgenerate

  // in_ready depends only on registered state and out_ready, never on in_valid.
  assign in_ready    = (state_q == S_STREAM) & (~out_valid_q | out_ready);
  assign beat_accept = in_valid & in_ready;

  always_comb begin
    lane_sel = lanes[lane_q];
    xored    = in_data ^ lane_sel;
    masked   = '0;
    for (int b = 0; b < KEEP_W; b++) begin
      masked[8*b +: 8] = in_keep[b] ? xored[8*b +: 8] : 8'h00;
    end
  end

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    ks_req_d    = ks_req_q;
    ks_buf_d    = ks_buf_q;
    lane_d      = lane_q;
    blk_cnt_d   = blk_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_FETCH;
          busy_d    = 1'b1;
          ks_req_d  = 1'b1;
          blk_cnt_d = 32'd0;
        end
      end
      S_FETCH: begin
        if (ks_valid) begin
          ks_buf_d  = ks_data;
          lane_d    = '0;
          ks_req_d  = 1'b0;
          blk_cnt_d = blk_cnt_q + 32'd1;
          state_d   = S_STREAM;
        end
      end
      S_STREAM: begin
        if (beat_accept) begin
          // A last beat ends the message even if lanes remain in the buffer.
          if (in_last) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end else if (lane_q == LANE_W'(LANES - 1)) begin
            state_d  = S_FETCH;
            ks_req_d = 1'b1;
          end else begin
            lane_d = lane_q + LANE_W'(1);
          end
        end
      end
      default: begin
        state_d  = S_IDLE;
        busy_d   = 1'b0;
        ks_req_d = 1'b0;
      end
    endcase

    // A new beat overwrites the output register even while it is being
    // drained, which sustains one beat per cycle.
    if (beat_accept) begin
      out_valid_d = 1'b1;
      out_data_d  = masked;
      out_keep_d  = in_keep;
      out_last_d  = in_last;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      ks_req_q    <= 1'b0;
      ks_buf_q    <= '0;
      lane_q      <= '0;
      blk_cnt_q   <= 32'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      ks_req_q    <= ks_req_d;
      ks_buf_q    <= ks_buf_d;
      lane_q      <= lane_d;
      blk_cnt_q   <= blk_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
    end
  end

  assign busy      = busy_q;
  assign ks_req    = ks_req_q;
  assign blk_cnt   = blk_cnt_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_keep  = out_keep_q;
  assign out_last  = out_last_q;

endmodule
`default_nettype wire

// File: tb/tb_chacha_ks_xor_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_chacha_ks_xor_stream
//  Description : Self-checking bench for chacha_ks_xor_stream. A keystream
//                responder answers ks_req; a reference model maps accepted
//                beat k of a message to lane k%4 of the (k/4)-th delivered
//                block and predicts every output beat.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_chacha_ks_xor_stream;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         busy;
  logic         ks_req;
  logic         ks_valid;
  logic [511:0] ks_data;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [15:0]  in_keep;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [15:0]  out_keep;
  logic         out_last;
  logic [31:0]  blk_cnt;

  chacha_ks_xor_stream #(.DATA_W(128)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
    .ks_req(ks_req), .ks_valid(ks_valid), .ks_data(ks_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_keep(in_keep), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_keep(out_keep), .out_last(out_last), .blk_cnt(blk_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] d;
    logic [15:0]  k;
    logic         l;
  } beat_t;

  beat_t        exp_q[$];
  logic [511:0] msg_blocks[$];
  logic [511:0] ks_script[$];

  int           n_cmp = 0;
  int           n_err = 0;
  int           acc_idx;
  bit           accepted;
  bit           ks_auto;
  bit           spur_en;
  int           ks_lat;
  int           wait_cnt;
  int           req_rises;
  bit           prev_req;
  bit           prev_stall;
  logic [127:0] prev_data;
  bit           chk_req_next;
  bit           chk_req_drop;

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Reference: XOR with the selected 128-bit slice, then zero disabled bytes.
  function automatic logic [127:0] model_beat(input logic [511:0] blk, input int lane,
                                              input logic [127:0] d, input logic [15:0] k);
    logic [511:0] sh;
    logic [127:0] v;
    sh = blk >> (128 * lane);
    v  = d ^ sh[127:0];
    for (int b = 0; b < 16; b++) if (!k[b]) v[8*b +: 8] = 8'h00;
    return v;
  endfunction

  // Keystream responder: answers a held ks_req after ks_lat cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (ks_auto) begin
        if (ks_valid) begin
          ks_valid = 1'b0;
        end else if (!rst_n) begin
          wait_cnt = 0;
        end else if (ks_req) begin
          if (wait_cnt >= ks_lat) begin
            ks_data  = (ks_script.size() != 0) ? ks_script.pop_front() : rand512();
            ks_valid = 1'b1;
            msg_blocks.push_back(ks_data);
            wait_cnt = 0;
          end else begin
            wait_cnt++;
          end
        end else begin
          wait_cnt = 0;
          // ks_req low means not in FETCH: a stray pulse must be ignored.
          if (spur_en && $urandom_range(0, 7) == 0) begin
            ks_data  = rand512();
            ks_valid = 1'b1;
          end
        end
      end
    end
  end

  // One clock cycle: evaluate handshakes 1ns after the negedge, then advance.
  task automatic cycle();
    beat_t e;
    beat_t g;
    #1;
    accepted = 1'b0;
    if (chk_req_next) begin
      n_cmp++;
      if (ks_req !== 1'b1) begin
        n_err++;
        $display("FAIL ks_req_reassert: got %b want 1", ks_req);
      end
      chk_req_next = 1'b0;
    end
    if (chk_req_drop) begin
      n_cmp++;
      if (ks_req !== 1'b0) begin
        n_err++;
        $display("FAIL ks_req_drop: got %b want 0", ks_req);
      end
      chk_req_drop = 1'b0;
    end
    if (ks_valid && ks_req) chk_req_drop = 1'b1;
    if (ks_req && !prev_req) req_rises++;
    prev_req = ks_req;
    if (!busy) begin
      n_cmp++;
      if (in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL in_ready_idle: got %b want 0", in_ready);
      end
    end
    if (prev_stall) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== prev_data) begin
        n_err++;
        $display("FAIL out_hold: got valid=%b data=%h want valid=1 data=%h", out_valid, out_data, prev_data);
      end
    end
    if (out_valid && !out_ready) begin
      n_cmp++;
      if (in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL in_ready_stall: got %b want 0", in_ready);
      end
      prev_stall = 1'b1;
      prev_data  = out_data;
    end else begin
      prev_stall = 1'b0;
    end
    if (in_valid && in_ready) begin
      accepted = 1'b1;
      if (acc_idx / 4 >= msg_blocks.size()) begin
        n_cmp++;
        n_err++;
        $display("FAIL beat_without_block: got beat %0d want block %0d delivered", acc_idx, acc_idx / 4);
      end else begin
        e.d = model_beat(msg_blocks[acc_idx / 4], acc_idx % 4, in_data, in_keep);
        e.k = in_keep;
        e.l = in_last;
        exp_q.push_back(e);
      end
      if (acc_idx % 4 == 3 && !in_last) chk_req_next = 1'b1;
      acc_idx++;
    end
    if (out_valid && out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_beat: got data=%h want no beat", out_data);
      end else begin
        e = exp_q.pop_front();
        g = '{d: out_data, k: out_keep, l: out_last};
        if (g !== e) begin
          n_err++;
          $display("FAIL out_beat: got data=%h keep=%h last=%b want data=%h keep=%h last=%b",
                   g.d, g.k, g.l, e.d, e.k, e.l);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic run_msg(input int nb, input int vp, input int rp, input bit fix,
                         input logic [127:0] fd, input logic [15:0] lk, input bit stall5,
                         input string name);
    int sent;
    int budget;
    int stall_cnt;
    int nblk;
    logic [127:0] cur;
    msg_blocks.delete();
    acc_idx   = 0;
    sent      = 0;
    budget    = 0;
    stall_cnt = 0;
    nblk      = (nb + 3) / 4;
    start = 1'b1;
    cycle();
    start = 1'b0;
    cur = fix ? fd : {$urandom, $urandom, $urandom, $urandom};
    while ((sent < nb || exp_q.size() != 0) && budget < 3000) begin
      in_valid = (sent < nb) && ($urandom_range(1, 100) <= vp);
      in_data  = cur;
      in_last  = (sent == nb - 1);
      in_keep  = in_last ? lk : (fix ? 16'hFFFF : 16'($urandom));
      if (stall5 && sent == 2 && stall_cnt < 5) begin
        out_ready = 1'b0;
        stall_cnt++;
      end else begin
        out_ready = ($urandom_range(1, 100) <= rp);
      end
      // Start while busy must be ignored.
      start = (sent < nb) && ($urandom_range(0, 9) == 0);
      cycle();
      start = 1'b0;
      if (accepted) begin
        sent++;
        cur = fix ? fd : {$urandom, $urandom, $urandom, $urandom};
      end
      budget++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    n_cmp++;
    if (budget >= 3000) begin
      n_err++;
      $display("FAIL %s timeout: got %0d beats sent want %0d", name, sent, nb);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s busy_end: got %b want 0", name, busy);
    end
    n_cmp++;
    if (blk_cnt !== 32'(nblk)) begin
      n_err++;
      $display("FAIL %s blk_cnt: got %0d want %0d", name, blk_cnt, nblk);
    end
    n_cmp++;
    if (msg_blocks.size() != nblk) begin
      n_err++;
      $display("FAIL %s blocks_used: got %0d want %0d", name, msg_blocks.size(), nblk);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({ks_req, busy, out_valid, out_last, in_ready} !== 5'b0 ||
        out_data !== 128'h0 || out_keep !== 16'h0 || blk_cnt !== 32'h0) begin
      n_err++;
      $display("FAIL reset_state: got req=%b busy=%b ov=%b ol=%b ir=%b od=%h ok=%h cnt=%0d want all 0",
               ks_req, busy, out_valid, out_last, in_ready, out_data, out_keep, blk_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_basic();
    int r0;
    ks_script.push_back({{32{4'hD}}, {32{4'hC}}, {32{4'hB}}, {32{4'hA}}});
    r0 = req_rises;
    run_msg(4, 100, 100, 1'b1, 128'h0, 16'hFFFF, 1'b0, "basic");
    n_cmp++;
    if (req_rises - r0 != 1) begin
      n_err++;
      $display("FAIL basic ks_req_episodes: got %0d want 1", req_rises - r0);
    end
  endtask

  task automatic test_multi_block();
    run_msg(6, 100, 100, 1'b1, {128{1'b1}}, 16'hFFFF, 1'b0, "multi");
  endtask

  task automatic test_partial_last();
    run_msg(3, 100, 100, 1'b1, {16{8'h11}}, 16'h00FF, 1'b0, "partial");
  endtask

  task automatic test_backpressure();
    run_msg(7, 100, 100, 1'b0, 128'h0, 16'hFFFF, 1'b1, "backpressure");
  endtask

  task automatic test_early_last();
    int r0;
    run_msg(2, 100, 100, 1'b0, 128'h0, 16'hFFFF, 1'b0, "early_last");
    r0 = req_rises;
    run_msg(4, 100, 100, 1'b0, 128'h0, 16'hFFFF, 1'b0, "after_early");
    n_cmp++;
    if (req_rises - r0 != 1) begin
      n_err++;
      $display("FAIL after_early ks_req_episodes: got %0d want 1", req_rises - r0);
    end
  endtask

  task automatic test_random();
    spur_en = 1'b1;
    for (int m = 0; m < 10; m++) begin
      run_msg($urandom_range(1, 11), 70, 70, 1'b0, 128'h0, 16'($urandom), 1'b0, "random");
    end
    spur_en = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    ks_auto = 1'b0;
    ks_valid = 1'b0;
    msg_blocks.delete();
    acc_idx = 0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    #1;
    n_cmp++;
    if (ks_req !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL fetch_entry: got req=%b busy=%b want 1 1", ks_req, busy);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ks_req !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: got req=%b busy=%b want 0 0", ks_req, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    chk_req_next = 1'b0;
    chk_req_drop = 1'b0;
    prev_stall   = 1'b0;
    cycle();
    ks_data  = rand512();
    ks_valid = 1'b1;
    in_valid = 1'b1;
    in_data  = 128'h1;
    in_keep  = 16'hFFFF;
    cycle();
    ks_valid = 1'b0;
    repeat (3) cycle();
    in_valid = 1'b0;
    #1;
    n_cmp++;
    if (ks_req !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 || blk_cnt !== 32'h0 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_pulse: got req=%b busy=%b ov=%b cnt=%0d ir=%b want 0 0 0 0 0",
               ks_req, busy, out_valid, blk_cnt, in_ready);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; ks_valid = 1'b0; ks_data = '0;
    in_valid = 1'b0; in_data = '0; in_keep = '0; in_last = 1'b0; out_ready = 1'b1;
    ks_auto = 1'b1; spur_en = 1'b0; ks_lat = 3; wait_cnt = 0;
    req_rises = 0; prev_req = 1'b0; prev_stall = 1'b0; prev_data = '0;
    chk_req_next = 1'b0; chk_req_drop = 1'b0; acc_idx = 0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_multi_block();
    test_partial_last();
    test_backpressure();
    test_early_last();
    test_random();
    test_reset_mid_fetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/chacha_ks_xor_stream.md
Name: chacha_ks_xor_stream

Overview:
- Consumes 512-bit ChaCha keystream blocks from the keystream unit over its ks_req/ks_valid interface.
- Slices each block into four 128-bit lanes and XORs them with a 128-bit valid/ready plaintext/ciphertext stream.
- Produces a registered 128-bit output stream with byte-keep and last markers.
- Sits directly downstream of the keystream unit in the ChaCha datapath of the PIM crypto engine.

Parameters:
- DATA_W, 128, stream beat width in bits; fixed at 128; 512/DATA_W = 4 lanes per keystream block.
- LANES, 4, keystream lanes per block; derived, not overridable.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse: begin a new message; honoured only when busy=0
- busy  out  1  high from accepted start until the in_last beat is accepted
- ks_req  out  1  keystream block request (registered level)
- ks_valid  in  1  one-cycle pulse: ks_data holds a fresh block
- ks_data  in  512  keystream block
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_data  in  128  input beat
- in_keep  in  16  byte enables; bit b covers in_data[8b+7:8b]
- in_last  in  1  final beat of message
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream ready
- out_data  out  128  XOR result; bytes with keep=0 forced to 0
- out_keep  out  16  copy of in_keep
- out_last  out  1  copy of in_last
- blk_cnt  out  32  keystream blocks consumed in current message

Behaviour:
- Reset values: ks_req=0, busy=0, out_valid=0, out_data=0, out_keep=0, out_last=0, blk_cnt=0. FSM resets to IDLE; keystream buffer and lane index are cleared.
- FSM states:
  - IDLE: in_ready=0. On start, go to FETCH, set busy=1, clear blk_cnt.
  - FETCH: ks_req=1, registered and held. The edge that samples ks_valid=1 captures ks_data into ks_buf, sets lane=0, drops ks_req, increments blk_cnt (wraps at 2^32), and moves to STREAM. ks_req is therefore low in the cycle after ks_valid. start is ignored in FETCH.
  - STREAM: in_ready = !out_valid | out_ready. No combinational path from in_valid to in_ready.
- Lane mapping: lane i = ks_buf[128*i+127 : 128*i]. Lanes are consumed in order 0,1,2,3.
- On each accepted beat:
  - out_data <= (in_data ^ lane_i) with bytes where keep=0 zeroed; out_keep <= in_keep; out_last <= in_last; out_valid <= 1.
  - The beat always consumes a whole lane, even if keep is partial.
- After an accepted beat:
  - If in_last: go to IDLE, busy <= 0, and discard remaining lanes. in_last has priority over lane exhaustion.
  - Else if lane was 3: go to FETCH.
  - Else: lane <= lane+1.
- Output register: out_valid clears on out_valid & out_ready when no new beat is accepted the same cycle. A simultaneous drain and accept keeps out_valid=1 and carries the new data. Throughput is one beat per cycle while in STREAM.
- Latency: 1 cycle from input accept to out_valid. Refetch bubble is the keystream unit latency plus 1 cycle.
- A ks_valid pulse outside FETCH is ignored.
- in_keep=0 with in_last=1 is legal: it emits an all-zero beat with out_last=1.
- start while busy=1 is ignored.
- Reset mid-operation returns everything to reset values immediately. Any in-flight keystream pulse after reset is ignored (the FSM is in IDLE).

Test Plan:
- Basic block: start, respond to ks_req after 3 cycles with ks_data={128'hD..D,128'hC..C,128'hB..B,128'hA..A}; send 4 beats of 128'h0, last on beat 4 -> outputs A..A, B..B, C..C, D..D; out_last only on beat 4; busy falls; blk_cnt=1; exactly one ks_req episode.
- Multi-block: 6 beats of 128'hFF..FF, two distinct keystream blocks -> beats 5–6 XOR lanes 0–1 of block 2; ks_req reasserts the cycle after beat 4 is accepted; blk_cnt=2.
- Partial last: last beat with in_keep=16'h00FF, in_data=128'h1111..11 -> out_data upper 8 bytes 0, lower 8 bytes = 0x11 ^ lane; out_keep=16'h00FF.
- Backpressure: hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 throughout, out_data stable, no beat lost or duplicated; on release, one beat per cycle.
- Early last: in_last on beat 2, then new start -> fresh ks_req issued; block-1 lanes 2–3 are never used.
- Reset mid-FETCH: assert rst_n=0 while ks_req=1, then deliver a ks_valid pulse after release -> ks_req=0, state IDLE, no output beat, blk_cnt=0.
